// File: rtl/minus3_serial_decoder_pkg.sv
// Shared types and constants for the serial excess-3 to BCD decoder.
package minus3_serial_decoder_pkg;

  typedef enum logic [2:0] {
    B0   = 3'd0,
    B1_N = 3'd1,
    B1_B = 3'd2,
    B2_N = 3'd3,
    B2_B = 3'd4,
    B3_N = 3'd5,
    B3_B = 3'd6
  } state_t;

  localparam logic [3:0] K_EXCESS = 4'b0011;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Position of the bit currently being received within the digit.
  function automatic logic [1:0] bit_index(input state_t st);
    case (st)
      B0:          return 2'd0;
      B1_N, B1_B:  return 2'd1;
      B2_N, B2_B:  return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic borrow_pending(input state_t st);
    return (st == B1_B) || (st == B2_B) || (st == B3_B);
  endfunction

endpackage

// File: rtl/minus3_serial_decoder_if.sv
// Serial input / decoded output bundle for minus3_serial_decoder.
interface minus3_serial_decoder_if #(parameter int NDIG = 2);

  logic              x;
  logic              en;
  logic              s;
  logic              err;
  logic [3:0]        digit;
  logic              digit_vld;
  logic [4*NDIG-1:0] word;
  logic              word_vld;

  modport master (
    output x, en,
    input  s, err, digit, digit_vld, word, word_vld
  );

  modport slave (
    input  x, en,
    output s, err, digit, digit_vld, word, word_vld
  );

endinterface

// File: rtl/minus3_serial_decoder_bit_cell.sv
// One-bit full subtractor: x - k - bin -> s, bout.
module minus3_serial_decoder_bit_cell (
  input  logic x,
  input  logic k,
  input  logic bin,
  output logic s,
  output logic bout
);

  assign s    = x ^ k ^ bin;
  assign bout = k ? (~x | bin) : (~x & bin);

endmodule

// File: rtl/minus3_serial_decoder.sv
// Serial excess-3 -> BCD decoder with digit/word assembly.
// Define MINUS3_STICKY_ERR_EN to make ERR hold until reset instead of pulsing.
module minus3_serial_decoder
  import minus3_serial_decoder_pkg::*;
#(
  parameter int NDIG = 2
) (
  input logic                  clk,
  input logic                  rst,
  minus3_serial_decoder_if.slave bus
);

  localparam int         W        = 4 * NDIG;
  localparam logic [3:0] CNT_LAST = 4'(NDIG - 1);

  state_t         state;
  state_t         state_next;
  logic           k;
  logic           b;
  logic           cell_s;
  logic           cell_bout;
  logic           closing;
  logic [2:0]     sr;
  logic [3:0]     cnt;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic [3:0]     result;
  logic           bad;

  minus3_serial_decoder_bit_cell u_cell (
    .x    (bus.x),
    .k    (k),
    .bin  (b),
    .s    (cell_s),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= B0;
    else     state <= state_next;
  end

  // The borrow out of the cell picks the _B/_N flavour of the next state.
  always_comb begin
    state_next = state;
    if (bus.en) begin
      case (state)
        B0:         state_next = cell_bout ? B1_B : B1_N;
        B1_N, B1_B: state_next = cell_bout ? B2_B : B2_N;
        B2_N, B2_B: state_next = cell_bout ? B3_B : B3_N;
        default:    state_next = B0;
      endcase
    end
  end

  always_comb begin
    k       = K_EXCESS[bit_index(state)];
    b       = borrow_pending(state);
    bus.s   = bus.en & cell_s;
    closing = bus.en && ((state == B3_N) || (state == B3_B));
  end

  assign result   = {cell_s, sr};
  assign bad      = cell_bout | (result > BCD_MAX);
  assign acc_next = W'({acc, result});

  // Datapath: collect S bits, publish digits and assembled words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr            <= '0;
      cnt           <= '0;
      acc           <= '0;
      bus.digit     <= '0;
      bus.digit_vld <= 1'b0;
      bus.word      <= '0;
      bus.word_vld  <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.digit_vld <= 1'b0;
      bus.word_vld  <= 1'b0;
`ifndef MINUS3_STICKY_ERR_EN
      bus.err       <= 1'b0;
`endif
      if (closing) begin
        bus.digit     <= result;
        bus.digit_vld <= 1'b1;
        acc           <= acc_next;
`ifdef MINUS3_STICKY_ERR_EN
        if (bad) bus.err <= 1'b1;
`else
        bus.err       <= bad;
`endif
        if (cnt == CNT_LAST) begin
          cnt          <= '0;
          bus.word     <= acc_next;
          bus.word_vld <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else if (bus.en) begin
        sr <= {cell_s, sr[2:1]};
      end
    end
  end

endmodule

// File: tb/tb_minus3_serial_decoder.sv
// Self-checking bench for minus3_serial_decoder (table, corner sequences, random).
module tb_minus3_serial_decoder;

  localparam int NDIG = 2;
`ifdef MINUS3_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic [3:0] code;
    logic [3:0] exp_digit;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minus3_serial_decoder_if #(.NDIG(NDIG)) tif ();

  minus3_serial_decoder #(.NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  int checks = 0;
  int errors = 0;
  int wv_seen = 0;

  // Reference model state: value of the bits received so far in this digit.
  int          m_nbits;
  int          m_val;
  int          m_dcount;
  logic [3:0]  m_digit;
  logic [31:0] m_word;
  logic        m_err;
  logic        m_dv;
  logic        m_wv;
  logic [3:0]  m_hist[$];

  vec_t tbl[12];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_nbits  = 0;
    m_val    = 0;
    m_dcount = 0;
    m_digit  = '0;
    m_word   = '0;
    m_err    = 1'b0;
    m_dv     = 1'b0;
    m_wv     = 1'b0;
    m_hist.delete();
  endtask

  task automatic apply_stimulus(input logic xb, input logic enb);
    int   partial;
    logic exp_s;
    logic bad;
    @(negedge clk);
    tif.x  = xb;
    tif.en = enb;
    #1;
    partial = m_val | (int'(xb) << m_nbits);
    exp_s   = enb && ((((partial - 3) >> m_nbits) & 1) != 0);
    check_output("s", {31'd0, tif.s}, {31'd0, exp_s});

    m_dv = 1'b0;
    m_wv = 1'b0;
    if (!STICKY) m_err = 1'b0;
    if (enb) begin
      m_val = partial;
      m_nbits++;
      if (m_nbits == 4) begin
        m_digit = 4'((m_val - 3) & 15);
        bad     = (m_val < 3) || (m_val > 12);
        m_dv    = 1'b1;
        m_err   = STICKY ? (m_err | bad) : bad;
        m_hist.push_back(m_digit);
        if (m_hist.size() > NDIG) void'(m_hist.pop_front());
        m_dcount++;
        if (m_dcount == NDIG) begin
          m_dcount = 0;
          m_word   = '0;
          for (int i = 0; i < NDIG; i++) m_word = (m_word << 4) | 32'(m_hist[i]);
          m_wv     = 1'b1;
        end
        m_nbits = 0;
        m_val   = 0;
      end
    end

    @(posedge clk);
    #1;
    if (tif.word_vld === 1'b1) wv_seen++;
    check_output("digit_vld", {31'd0, tif.digit_vld}, {31'd0, m_dv});
    check_output("digit", {28'd0, tif.digit}, {28'd0, m_digit});
    check_output("err", {31'd0, tif.err}, {31'd0, m_err});
    check_output("word_vld", {31'd0, tif.word_vld}, {31'd0, m_wv});
    check_output("word", 32'(tif.word), m_word);
  endtask

  task automatic send_digit(input logic [3:0] code);
    for (int i = 0; i < 4; i++) apply_stimulus(code[i], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    tif.en = 1'b0;
    #1;
    check_output("rst_digit", {28'd0, tif.digit}, 32'd0);
    check_output("rst_word", 32'(tif.word), 32'd0);
    check_output("rst_err", {31'd0, tif.err}, 32'd0);
    check_output("rst_dvld", {31'd0, tif.digit_vld}, 32'd0);
    check_output("rst_wvld", {31'd0, tif.word_vld}, 32'd0);
    check_output("rst_s", {31'd0, tif.s}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b0011, 4'd0};
    tbl[1]  = '{4'b1100, 4'd9};
    tbl[2]  = '{4'b0010, 4'hF};
    tbl[3]  = '{4'b1101, 4'hA};
    tbl[4]  = '{4'b0000, 4'hD};
    tbl[5]  = '{4'b1111, 4'hC};
    tbl[6]  = '{4'b0111, 4'd4};
    tbl[7]  = '{4'b1010, 4'd7};
    tbl[8]  = '{4'b0100, 4'd1};
    tbl[9]  = '{4'b1000, 4'd5};
    tbl[10] = '{4'b0101, 4'd2};
    tbl[11] = '{4'b1001, 4'd6};

    rst    = 1'b1;
    tif.x  = 1'b0;
    tif.en = 1'b0;
    model_reset();
    do_reset();

    // Back-to-back table digits, each compared against its tabulated value.
    foreach (tbl[i]) begin
      send_digit(tbl[i].code);
      check_output("tbl_digit", {28'd0, tif.digit}, {28'd0, tbl[i].exp_digit});
    end

    // Illegal digit then a legal one: pulse vs hold of ERR.
    do_reset();
    send_digit(4'b0010);
    check_output("err_low", {31'd0, tif.err}, 32'd1);
    idle(1);
    check_output("err_idle", {31'd0, tif.err}, {31'd0, STICKY});
    send_digit(4'b0011);
    check_output("err_after_good", {31'd0, tif.err}, {31'd0, STICKY});
    send_digit(4'b1101);
    check_output("err_high", {31'd0, tif.err}, 32'd1);

    // Two digits form one word with the first digit in the upper nibble.
    do_reset();
    wv_seen = 0;
    send_digit(4'b0100);
    send_digit(4'b1000);
    check_output("word_15", 32'(tif.word), 32'h15);
    idle(2);
    check_output("word_vld_once", 32'(wv_seen), 32'd1);

    // EN gap mid-digit holds state.
    do_reset();
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    idle(3);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    check_output("gap_digit", {28'd0, tif.digit}, 32'd4);

    // Reset mid-digit, then a fresh digit decodes cleanly.
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    do_reset();
    send_digit(4'b1010);
    check_output("post_rst_digit", {28'd0, tif.digit}, 32'd7);

    // Random digits with random EN gaps and occasional resets.
    for (int d = 0; d < 150; d++) begin
      logic [3:0] code;
      code = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 59) == 0) do_reset();
        apply_stimulus(code[i], 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
